// File: rtl/row_driver.sv
// row_driver: LED-matrix row drive with column blanking and double-buffered frames; define BRIGHTNESS_PWM_EN for PWM dimming
module row_driver #(
  parameter int ROWS         = 7,
  parameter int BLANK_CYCLES = 2
`ifdef BRIGHTNESS_PWM_EN
  ,
  parameter int PWM_BITS     = 4
`endif
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [2:0]          col_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [1:0]          wr_col_i,
  input  logic [ROWS-1:0]     wr_rows_i,
  input  logic                commit_i,
  output logic [ROWS-1:0]     row_o,
  output logic                frame_start_o,
  output logic                col_error_o
`ifdef BRIGHTNESS_PWM_EN
  ,
  input  logic [PWM_BITS-1:0] brightness_i
`endif
);
  localparam int CW = $clog2(BLANK_CYCLES + 2);
  typedef enum logic [1:0] {BLANK, DRIVE, FAULT} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      col_q;
  logic [ROWS-1:0] row_q;
  logic            fs_q;
  logic            err_q;
  logic            pending_q;
  logic [ROWS-1:0] front_q [0:2];
  logic [ROWS-1:0] back_q [0:2];
  logic            onehot_d;
  logic            change_d;
  logic [1:0]      idx_d;
  logic            fs_d;
  logic            pending_d;
  logic [ROWS-1:0] drive_d;
`ifdef BRIGHTNESS_PWM_EN
  logic [PWM_BITS-1:0] pwm_q;
  always_ff @(posedge clock_i)
    pwm_q <= reset_i ? '0 : pwm_q + PWM_BITS'(1);
`endif
  always_comb begin
    onehot_d  = $onehot(col_i);
    change_d  = col_i != col_q;
    idx_d     = col_i[2] ? 2'd0 : col_i[1] ? 2'd1 : 2'd2;
    fs_d      = onehot_d && change_d && col_i[2] && state_q != FAULT;
    pending_d = pending_q ? !fs_d : commit_i;
`ifdef BRIGHTNESS_PWM_EN
    drive_d   = front_q[idx_d] & {ROWS{pwm_q < brightness_i}};
`else
    drive_d   = front_q[idx_d];
`endif
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= BLANK;
      cnt_q   <= CW'(BLANK_CYCLES);
      col_q   <= 3'b100;
      row_q   <= '0;
      fs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      col_q <= col_i;
      fs_q  <= fs_d;
      if (!onehot_d) begin
        state_q <= FAULT;
        row_q   <= '0;
        err_q   <= 1'b1;
      end else if (change_d || state_q == FAULT) begin
        state_q <= BLANK;
        cnt_q   <= CW'(BLANK_CYCLES);
        row_q   <= '0;
        err_q   <= 1'b0;
      end else if (state_q == BLANK) begin
        state_q <= cnt_q == '0 ? DRIVE : BLANK;
        cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        row_q   <= cnt_q == '0 ? drive_d : '0;
      end else begin
        row_q <= drive_d;
      end
    end
  end
  // writes are blocked while pending, so a copy never races a write
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
    end else begin
      pending_q <= pending_d;
      if (wr_valid_i && !pending_q && wr_col_i != 2'd3) back_q[wr_col_i] <= wr_rows_i;
      if (fs_d && pending_q)
        for (int i = 0; i < 3; i++) front_q[i] <= back_q[i];
    end
  end
  assign wr_ready_o    = !pending_q;
  assign row_o         = row_q;
  assign frame_start_o = fs_q;
  assign col_error_o   = err_q;
endmodule

// File: tb/tb_row_driver.sv
// tb_row_driver: directed checks of blanking latency, frame commit, fault recovery and reset
module tb_row_driver;
  logic       clock_i = 1'b0;
  logic       reset_i;
  logic [2:0] col_i;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [1:0] wr_col_i;
  logic [6:0] wr_rows_i;
  logic       commit_i;
  logic [6:0] row_o;
  logic       frame_start_o;
  logic       col_error_o;
  int total = 0;
  int bad = 0;
  row_driver dut (
    .clock_i(clock_i), .reset_i(reset_i), .col_i(col_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_col_i(wr_col_i),
    .wr_rows_i(wr_rows_i), .commit_i(commit_i), .row_o(row_o),
    .frame_start_o(frame_start_o), .col_error_o(col_error_o)
  );
  always #5 clock_i = ~clock_i;
  task automatic step(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] c, input logic [6:0] rows, input logic cm);
    wr_valid_i = 1'b1;
    wr_col_i   = c;
    wr_rows_i  = rows;
    commit_i   = cm;
    step(1);
    wr_valid_i = 1'b0;
    commit_i   = 1'b0;
  endtask
  // one 8-clock column slot: blank on the change edge plus two, data on the third
  task automatic run_col(input logic [2:0] c, input logic [6:0] exp, input logic fs, input logic cm);
    col_i    = c;
    commit_i = cm;
    step(1);
    commit_i = 1'b0;
    chk("frame_start", frame_start_o, fs);
    chk("blank0", row_o, 0);
    step(2);
    chk("blank2", row_o, 0);
    chk("fs_pulse", frame_start_o, 0);
    step(1);
    chk("drive", row_o, exp);
    step(4);
  endtask
  initial begin
    reset_i = 1'b1; col_i = 3'b100; wr_valid_i = 1'b0; wr_col_i = 2'd0; wr_rows_i = '0; commit_i = 1'b0;
    step(2);
    chk("rst_row", row_o, 0);
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_err", col_error_o, 0);
    chk("rst_fs", frame_start_o, 0);
    reset_i = 1'b0;
    step(3);
    chk("post_rst_row", row_o, 0);
    wr(2'd0, 7'h41, 1'b0);
    wr(2'd1, 7'h22, 1'b0);
    wr(2'd2, 7'h14, 1'b0);
    chk("ready_idle", wr_ready_o, 1);
    wr(2'd0, 7'h41, 1'b1);
    chk("ready_pending", wr_ready_o, 0);
    run_col(3'b010, 7'h00, 1'b0, 1'b0);
    run_col(3'b001, 7'h00, 1'b0, 1'b0);
    run_col(3'b100, 7'h41, 1'b1, 1'b0);
    chk("ready_after_swap", wr_ready_o, 1);
    run_col(3'b010, 7'h22, 1'b0, 1'b0);
    run_col(3'b001, 7'h14, 1'b0, 1'b0);
    run_col(3'b100, 7'h41, 1'b1, 1'b0);
    wr(2'd2, 7'h7F, 1'b1);
    chk("ready_mid_commit", wr_ready_o, 0);
    run_col(3'b010, 7'h22, 1'b0, 1'b0);
    run_col(3'b001, 7'h14, 1'b0, 1'b0);
    chk("still_pending", wr_ready_o, 0);
    run_col(3'b100, 7'h41, 1'b1, 1'b0);
    chk("ready_swapped", wr_ready_o, 1);
    run_col(3'b010, 7'h22, 1'b0, 1'b0);
    run_col(3'b001, 7'h7F, 1'b0, 1'b0);
    wr(2'd1, 7'h33, 1'b0);
    run_col(3'b100, 7'h41, 1'b1, 1'b1);
    chk("commit_on_fs_pending", wr_ready_o, 0);
    run_col(3'b010, 7'h22, 1'b0, 1'b0);
    run_col(3'b001, 7'h7F, 1'b0, 1'b0);
    run_col(3'b100, 7'h41, 1'b1, 1'b0);
    run_col(3'b010, 7'h33, 1'b0, 1'b0);
    col_i = 3'b000;
    step(1);
    chk("fault_err", col_error_o, 1);
    chk("fault_row", row_o, 0);
    step(2);
    chk("fault_err_held", col_error_o, 1);
    run_col(3'b010, 7'h33, 1'b0, 1'b0);
    chk("fault_cleared", col_error_o, 0);
    col_i = 3'b111;
    step(1);
    chk("fault111", col_error_o, 1);
    run_col(3'b100, 7'h41, 1'b0, 1'b0);
    wr(2'd0, 7'h55, 1'b1);
    chk("pending_before_rst", wr_ready_o, 0);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    chk("rst_mid_ready", wr_ready_o, 1);
    chk("rst_mid_row", row_o, 0);
    step(3);
    chk("rst_front0", row_o, 0);
    wr(2'd3, 7'h7F, 1'b1);
    run_col(3'b010, 7'h00, 1'b0, 1'b0);
    run_col(3'b001, 7'h00, 1'b0, 1'b0);
    run_col(3'b100, 7'h00, 1'b1, 1'b0);
    run_col(3'b010, 7'h00, 1'b0, 1'b0);
    run_col(3'b001, 7'h00, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
